// File: rtl/ipif_axil_regfile_if.sv
// AXI4-Lite slave channel bundle for the IPIF register file.
// The master modport is the bus side and the slave modport is the register file side.
interface ipif_axil_regfile_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/ipif_axil_regfile.sv
// AXI4-Lite register file at the bus-clock end of the IPIF parameter path.
// Define IPIF_AXIL_RDPIPE_EN to add one extra register stage on the read data path.
module ipif_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_REG              = 2,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                bus_clk,
  input  logic                                bus_clk_aresetn,
  ipif_axil_regfile_if.slave                  s_axi,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_from_bus,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_to_bus,
  output logic [N_REG-1:0]                    wr_pulse
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t         w_state;
  r_state_t         r_state;
  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0]    w_data;
  logic [NB-1:0]    w_strb;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    rd_word;
  logic             aw_fire;
  logic             w_fire;
  logic             aw_done;
  logic             w_done;
  logic             aw_in_range;
  logic             rd_in_range;
  logic             unused_ok;

  assign aw_fire     = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_fire      = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign aw_done     = aw_held || aw_fire;
  assign w_done      = w_held || w_fire;
  assign aw_in_range = int'(aw_idx) < N_REG;
  assign rd_in_range = int'(ar_idx) < N_REG;
  assign unused_ok   = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Out-of-range indices select nothing, so they read back as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (int'(ar_idx) == i) rd_word = params_to_bus[i*DW +: DW];
    end
  end

  always_ff @(posedge bus_clk or negedge bus_clk_aresetn) begin
    if (!bus_clk_aresetn) begin
      w_state             <= W_IDLE;
      aw_held             <= 1'b0;
      w_held              <= 1'b0;
      aw_idx              <= '0;
      w_data              <= '0;
      w_strb              <= '0;
      s_axi.S_AXI_AWREADY <= 1'b0;
      s_axi.S_AXI_WREADY  <= 1'b0;
      s_axi.S_AXI_BVALID  <= 1'b0;
      s_axi.S_AXI_BRESP   <= 2'b00;
      params_from_bus     <= RESET_VALUE;
      wr_pulse            <= '0;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          end
          if (w_fire) begin
            w_held <= 1'b1;
            w_data <= s_axi.S_AXI_WDATA;
            w_strb <= s_axi.S_AXI_WSTRB;
          end
          if (aw_done && w_done) begin
            w_state             <= W_COMMIT;
            s_axi.S_AXI_AWREADY <= 1'b0;
            s_axi.S_AXI_WREADY  <= 1'b0;
          end else begin
            s_axi.S_AXI_AWREADY <= !aw_done;
            s_axi.S_AXI_WREADY  <= !w_done;
          end
        end
        W_COMMIT: begin
          for (int i = 0; i < N_REG; i++) begin
            if (int'(aw_idx) == i) begin
              for (int b = 0; b < NB; b++) begin
                if (w_strb[b]) params_from_bus[i*DW + b*8 +: 8] <= w_data[b*8 +: 8];
              end
              wr_pulse[i] <= 1'b1;
            end
          end
          s_axi.S_AXI_BRESP  <= aw_in_range ? 2'b00 : 2'b10;
          s_axi.S_AXI_BVALID <= 1'b1;
          w_state            <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            s_axi.S_AXI_BVALID  <= 1'b0;
            s_axi.S_AXI_BRESP   <= 2'b00;
            aw_held             <= 1'b0;
            w_held              <= 1'b0;
            aw_idx              <= '0;
            w_data              <= '0;
            w_strb              <= '0;
            s_axi.S_AXI_AWREADY <= 1'b1;
            s_axi.S_AXI_WREADY  <= 1'b1;
            w_state             <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

`ifdef IPIF_AXIL_RDPIPE_EN
  logic          rd_staged;
  logic [DW-1:0] rd_stage_data;
  logic          rd_stage_err;
`endif

  // RVALID low inside R_DATA means the response is still being assembled.
  always_ff @(posedge bus_clk or negedge bus_clk_aresetn) begin
    if (!bus_clk_aresetn) begin
      r_state             <= R_IDLE;
      ar_idx              <= '0;
      s_axi.S_AXI_ARREADY <= 1'b0;
      s_axi.S_AXI_RVALID  <= 1'b0;
      s_axi.S_AXI_RDATA   <= '0;
      s_axi.S_AXI_RRESP   <= 2'b00;
`ifdef IPIF_AXIL_RDPIPE_EN
      rd_staged           <= 1'b0;
      rd_stage_data       <= '0;
      rd_stage_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.S_AXI_ARREADY && s_axi.S_AXI_ARVALID) begin
            ar_idx              <= s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
            s_axi.S_AXI_ARREADY <= 1'b0;
            r_state             <= R_DATA;
          end else begin
            s_axi.S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RVALID) begin
            if (s_axi.S_AXI_RREADY) begin
              s_axi.S_AXI_RVALID  <= 1'b0;
              s_axi.S_AXI_RDATA   <= '0;
              s_axi.S_AXI_RRESP   <= 2'b00;
              s_axi.S_AXI_ARREADY <= 1'b1;
              ar_idx              <= '0;
              r_state             <= R_IDLE;
`ifdef IPIF_AXIL_RDPIPE_EN
              rd_staged           <= 1'b0;
`endif
            end
          end else begin
`ifdef IPIF_AXIL_RDPIPE_EN
            if (!rd_staged) begin
              rd_staged     <= 1'b1;
              rd_stage_data <= rd_word;
              rd_stage_err  <= !rd_in_range;
            end else begin
              s_axi.S_AXI_RVALID <= 1'b1;
              s_axi.S_AXI_RDATA  <= rd_stage_data;
              s_axi.S_AXI_RRESP  <= rd_stage_err ? 2'b10 : 2'b00;
            end
`else
            s_axi.S_AXI_RVALID <= 1'b1;
            s_axi.S_AXI_RDATA  <= rd_word;
            s_axi.S_AXI_RRESP  <= rd_in_range ? 2'b00 : 2'b10;
`endif
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipif_axil_regfile.sv
// Self-checking bench for ipif_axil_regfile: a transaction-level model predicts every output each cycle.
// Build with IPIF_AXIL_RDPIPE_EN defined to exercise the two-cycle read path.
module tb_ipif_axil_regfile;
  localparam int N_REG = 2;
  localparam logic [63:0] RV = {32'h1234_5678, 32'h0000_0000};
`ifdef IPIF_AXIL_RDPIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        bus_clk = 1'b0;
  logic        bus_clk_aresetn = 1'b1;
  logic [63:0] params_from_bus;
  logic [63:0] params_to_bus;
  logic [1:0]  wr_pulse;
  int          checks = 0;
  int          errors = 0;

  ipif_axil_regfile_if #(.C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)) bus ();

  ipif_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .N_REG(N_REG), .RESET_VALUE(RV)
  ) dut (
    .bus_clk(bus_clk), .bus_clk_aresetn(bus_clk_aresetn), .s_axi(bus),
    .params_from_bus(params_from_bus), .params_to_bus(params_to_bus), .wr_pulse(wr_pulse)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Model: handshakes time-stamp the transaction; commit one edge after both halves are in,
  // read data sampled one edge after AR and shown RD_LAT edges after AR.
  int          edge_n;
  bit          m_started, m_aw_have, m_w_have, m_bvalid, m_ar_busy, m_rvalid;
  int          m_aw_idx, m_ar_idx, m_commit_at, m_sample_at, m_show_at;
  logic [31:0] m_wdata, m_rsample, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp, m_rsample_resp;
  logic [1:0]  m_pulse;
  logic [63:0] m_params;

  always @(posedge bus_clk or negedge bus_clk_aresetn) begin
    if (!bus_clk_aresetn) begin
      edge_n = 0; m_started = 0; m_aw_have = 0; m_w_have = 0; m_bvalid = 0;
      m_ar_busy = 0; m_rvalid = 0; m_aw_idx = 0; m_ar_idx = 0;
      m_commit_at = -1; m_sample_at = -1; m_show_at = -1;
      m_wdata = '0; m_wstrb = '0; m_rsample = '0; m_rdata = '0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rsample_resp = 2'b00;
      m_pulse = '0; m_params = RV;
    end else begin
      edge_n++;
      m_pulse = '0;
      if (edge_n == m_commit_at) begin
        m_commit_at = -1;
        if (m_aw_idx < N_REG) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_params[m_aw_idx*32 + b*8 +: 8] = m_wdata[b*8 +: 8];
          m_pulse[m_aw_idx] = 1'b1;
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_bvalid = 1;
      end else if (m_bvalid && bus.S_AXI_BREADY) begin
        m_bvalid = 0; m_bresp = 2'b00; m_aw_have = 0; m_w_have = 0;
      end
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) begin
        m_aw_have = 1; m_aw_idx = int'(bus.S_AXI_AWADDR >> 2);
      end
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) begin
        m_w_have = 1; m_wdata = bus.S_AXI_WDATA; m_wstrb = bus.S_AXI_WSTRB;
      end
      if (m_aw_have && m_w_have && !m_bvalid && m_commit_at < 0) m_commit_at = edge_n + 1;

      if (m_rvalid && bus.S_AXI_RREADY) begin
        m_rvalid = 0; m_ar_busy = 0;
      end
      if (edge_n == m_sample_at) begin
        m_rsample      = (m_ar_idx < N_REG) ? params_to_bus[m_ar_idx*32 +: 32] : 32'h0;
        m_rsample_resp = (m_ar_idx < N_REG) ? 2'b00 : 2'b10;
      end
      if (edge_n == m_show_at) begin
        m_rvalid = 1; m_rdata = m_rsample; m_rresp = m_rsample_resp;
      end
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) begin
        m_ar_busy = 1; m_ar_idx = int'(bus.S_AXI_ARADDR >> 2);
        m_sample_at = edge_n + 1; m_show_at = edge_n + RD_LAT;
      end
      m_started = 1;
    end
  end

  int          b_seen = 0;
  int          pulse_count = 0;
  logic [1:0]  last_pulse = '0;

  always @(negedge bus_clk) begin
    check_output("params_from_bus", params_from_bus, m_params);
    check_output("wr_pulse", {62'b0, wr_pulse}, {62'b0, m_pulse});
    check_output("awready", {63'b0, bus.S_AXI_AWREADY}, {63'b0, m_started && !m_aw_have});
    check_output("wready", {63'b0, bus.S_AXI_WREADY}, {63'b0, m_started && !m_w_have});
    check_output("arready", {63'b0, bus.S_AXI_ARREADY}, {63'b0, m_started && !m_ar_busy});
    check_output("bvalid", {63'b0, bus.S_AXI_BVALID}, {63'b0, m_bvalid});
    check_output("rvalid", {63'b0, bus.S_AXI_RVALID}, {63'b0, m_rvalid});
    if (m_bvalid) check_output("bresp", {62'b0, bus.S_AXI_BRESP}, {62'b0, m_bresp});
    if (m_rvalid) begin
      check_output("rdata", {32'b0, bus.S_AXI_RDATA}, {32'b0, m_rdata});
      check_output("rresp", {62'b0, bus.S_AXI_RRESP}, {62'b0, m_rresp});
    end
    if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) b_seen++;
    if (wr_pulse != 2'b00) begin
      pulse_count++;
      last_pulse = wr_pulse;
    end
  end

  task automatic apply_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input bit wait_b, output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    resp = 2'b11;
    @(negedge bus_clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_WVALID = 1'b1;
    aw_done = 0; w_done = 0;
    for (cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      if (cyc >= w_lead && !aw_done) bus.S_AXI_AWVALID = 1'b1;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge bus_clk);
      if (aw_fire) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  bus.S_AXI_WVALID = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      check_output("write_handshake_timeout", 64'd0, 64'd1);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      return;
    end
    if (wait_b) begin
      for (cyc = 0; cyc < 20 && !bus.S_AXI_BVALID; cyc++) @(negedge bus_clk);
      if (!bus.S_AXI_BVALID) check_output("bvalid_timeout", 64'd0, 64'd1);
      else begin
        resp = bus.S_AXI_BRESP;
        @(negedge bus_clk);
      end
    end
  endtask

  task automatic apply_read(input logic [7:0] addr, input int stall, input logic [31:0] exp_data,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc;
    data = 'x; resp = 2'b11; lat = -1;
    @(negedge bus_clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    for (cyc = 0; cyc < 20 && !bus.S_AXI_ARREADY; cyc++) @(negedge bus_clk);
    if (!bus.S_AXI_ARREADY) begin
      check_output("arready_timeout", 64'd0, 64'd1);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    @(negedge bus_clk);
    bus.S_AXI_ARVALID = 1'b0;
    lat = 0;
    while (!bus.S_AXI_RVALID && lat < 20) begin
      @(negedge bus_clk);
      lat++;
    end
    if (!bus.S_AXI_RVALID) begin
      check_output("rvalid_timeout", 64'd0, 64'd1);
      return;
    end
    data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
    for (int s = 0; s < stall; s++) begin
      check_output("rdata_hold", {32'b0, bus.S_AXI_RDATA}, {32'b0, exp_data});
      check_output("arready_low_stall", {63'b0, bus.S_AXI_ARREADY}, 64'd0);
      params_to_bus = ~params_to_bus;
      @(negedge bus_clk);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(negedge bus_clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  logic [1:0]  resp, rresp2;
  logic [31:0] rdata;
  int          lat;

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    params_to_bus = '0;
    #1 bus_clk_aresetn = 1'b0;
    repeat (3) @(negedge bus_clk);
    check_output("reset_params", params_from_bus, RV);
    check_output("reset_readies", {61'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 64'd0);
    check_output("reset_valids", {62'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 64'd0);
    check_output("reset_rdata", {32'b0, bus.S_AXI_RDATA}, 64'd0);
    check_output("reset_wr_pulse", {62'b0, wr_pulse}, 64'd0);
    bus_clk_aresetn = 1'b1;
    @(negedge bus_clk);
    check_output("readies_after_reset", {61'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 64'd7);

    $display("[TB] simultaneous write");
    apply_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 1, resp);
    check_output("t1_bresp", {62'b0, resp}, 64'd0);
    check_output("t1_params", params_from_bus, 64'hDEADBEEF_00000000);
    check_output("t1_pulse_count", pulse_count, 64'd1);
    check_output("t1_pulse_bit", {62'b0, last_pulse}, 64'd2);
    check_output("t1_b_count", b_seen, 64'd1);

    $display("[TB] W before AW, partial strobe");
    apply_write(8'h00, 32'h11223344, 4'b0101, 3, 1, resp);
    check_output("t2_bresp", {62'b0, resp}, 64'd0);
    check_output("t2_params", params_from_bus, 64'hDEADBEEF_00220044);
    check_output("t2_b_count", b_seen, 64'd2);
    check_output("t2_pulse_bit", {62'b0, last_pulse}, 64'd1);

    $display("[TB] out-of-range write and read");
    apply_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 1, resp);
    check_output("t3_bresp", {62'b0, resp}, 64'd2);
    check_output("t3_params", params_from_bus, 64'hDEADBEEF_00220044);
    check_output("t3_pulse_count", pulse_count, 64'd2);
    params_to_bus = 64'h0BADF00D_A5A5A5A5;
    apply_read(8'h0C, 0, 32'h0, rdata, rresp2, lat);
    check_output("t4_rdata", {32'b0, rdata}, 64'd0);
    check_output("t4_rresp", {62'b0, rresp2}, 64'd2);

    $display("[TB] read with stalled RREADY");
    apply_read(8'h00, 5, 32'hA5A5A5A5, rdata, rresp2, lat);
    check_output("t5_rdata", {32'b0, rdata}, 64'hA5A5A5A5);
    check_output("t5_rresp", {62'b0, rresp2}, 64'd0);
    check_output("t5_latency", lat, RD_LAT);
    params_to_bus = 64'h0BADF00D_A5A5A5A5;
    apply_read(8'h07, 0, 32'h0BADF00D, rdata, rresp2, lat);
    check_output("t6_rdata_from_to_bus", {32'b0, rdata}, 64'h0BADF00D);

    $display("[TB] back-to-back writes to one register");
    apply_write(8'h00, 32'hFFFF0000, 4'b1100, 0, 1, resp);
    apply_write(8'h03, 32'h000000AB, 4'b0001, 0, 1, resp);
    check_output("t7_params", params_from_bus, 64'hDEADBEEF_FFFF00AB);

    $display("[TB] concurrent read and write");
    fork
      apply_write(8'h04, 32'h13579BDF, 4'hF, 0, 1, resp);
      apply_read(8'h04, 0, 32'h0BADF00D, rdata, rresp2, lat);
    join
    check_output("t8_rdata", {32'b0, rdata}, 64'h0BADF00D);
    check_output("t8_params", params_from_bus, 64'h13579BDF_FFFF00AB);

    $display("[TB] reset during write response");
    bus.S_AXI_BREADY = 1'b0;
    apply_write(8'h00, 32'h55AA55AA, 4'hF, 0, 0, resp);
    repeat (2) @(negedge bus_clk);
    check_output("t9_bvalid_before_reset", {63'b0, bus.S_AXI_BVALID}, 64'd1);
    #2 bus_clk_aresetn = 1'b0;
    #1;
    check_output("t9_bvalid_in_reset", {63'b0, bus.S_AXI_BVALID}, 64'd0);
    check_output("t9_params_in_reset", params_from_bus, RV);
    repeat (2) @(negedge bus_clk);
    #2 bus_clk_aresetn = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    apply_write(8'h04, 32'h0BADCAFE, 4'hF, 0, 1, resp);
    check_output("t10_bresp", {62'b0, resp}, 64'd0);
    check_output("t10_params", params_from_bus, 64'h0BADCAFE_00000000);

    repeat (3) @(negedge bus_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
